// File: rtl/hex_display_pkg.sv
// Shared constants and state encoding for the hex-display arbiter slice.
package hex_display_pkg;

  localparam logic [1:0] HEX_PIO_DATA_ADDR = 2'd0;
  localparam int         HEX_DW            = 16;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

endpackage

// File: rtl/hex_display_arbiter_if.sv
// Avalon-MM write-only link from the arbiter (master) to the hex PIO (slave).
interface hex_display_arbiter_if;

  logic [1:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [31:0] avm_writedata;

  modport master (
    output avm_address,
    output avm_chipselect,
    output avm_write_n,
    output avm_writedata
  );

  modport slave (
    input avm_address,
    input avm_chipselect,
    input avm_write_n,
    input avm_writedata
  );

endinterface

// File: rtl/hex_rr_picker.sv
// Combinational round-robin pick: first set request at or after rr_ptr, wrapping.
module hex_rr_picker #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic [1:0]      index,
  output logic            valid
);

  logic [3:0] req_ext;
  logic [2:0] cand;

  assign req_ext = 4'(req);

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    index = '0;
    valid = 1'b0;
    cand  = '0;
    grant = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr} + 3'(k);
      if (cand >= 3'(NREQ)) cand = cand - 3'(NREQ);
      if (!valid && req_ext[cand[1:0]]) begin
        valid = 1'b1;
        index = cand[1:0];
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      grant[i] = valid && (index == 2'(i));
    end
  end

endmodule

// File: rtl/hex_display_arbiter.sv
// Round-robin owner of the hex PIO with a minimum dwell; issues single-cycle Avalon-MM writes.
module hex_display_arbiter
  import hex_display_pkg::*;
#(
  parameter int NREQ        = 2,
  parameter int DW          = HEX_DW,
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int CNT_W       = 26
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      grant,
  output logic [1:0]           owner,
  output logic                 busy,
  hex_display_arbiter_if.master avm
);

  localparam arb_state_e LOAD_STATE = (HOLD_CYCLES == 0) ? IDLE : HOLD;

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [1:0]       rr_ptr_q, rr_ptr_d;
  logic [1:0]       owner_q, owner_d;
  logic [1:0]       addr_q, addr_d;
  logic             cs_q, cs_d;
  logic             write_n_q, write_n_d;
  logic [31:0]      wdata_q, wdata_d;

  logic [3:0]    req_ext;
  logic [DW-1:0] data_arr [4];
  logic [NREQ-1:0] pick_grant;
  logic [1:0]    pick_idx;
  logic          pick_valid;
  logic          pick_en;
  logic          granted;
  logic [1:0]    sel_idx;
  logic [2:0]    rr_next;

  assign req_ext = 4'(req);

  for (genvar g = 0; g < 4; g++) begin : g_data
    if (g < NREQ) begin : g_used
      assign data_arr[g] = req_data[g*DW +: DW];
    end else begin : g_unused
      assign data_arr[g] = '0;
    end
  end

  hex_rr_picker #(.NREQ(NREQ)) u_picker (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .grant  (pick_grant),
    .index  (pick_idx),
    .valid  (pick_valid)
  );

  // An exhausted dwell arbitrates exactly like IDLE; otherwise only the owner may refresh.
  always_comb begin
    pick_en = (state_q == IDLE) || (hold_cnt_q == '0);
    granted = pick_en ? pick_valid : req_ext[owner_q];
    sel_idx = pick_en ? pick_idx : owner_q;
    rr_next = {1'b0, pick_idx} + 3'd1;
    if (rr_next == 3'(NREQ)) rr_next = '0;

    grant = '0;
    for (int i = 0; i < NREQ; i++) begin
      grant[i] = granted && (sel_idx == 2'(i));
    end

    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    if (pick_en) begin
      if (pick_valid) begin
        owner_d    = pick_idx;
        rr_ptr_d   = rr_next[1:0];
        hold_cnt_d = CNT_W'(HOLD_CYCLES);
        state_d    = LOAD_STATE;
      end else begin
        state_d = IDLE;
      end
    end else begin
      hold_cnt_d = hold_cnt_q - 1'b1;
    end

    addr_d    = HEX_PIO_DATA_ADDR;
    cs_d      = granted;
    write_n_d = !granted;
    wdata_d   = granted ? 32'(data_arr[sel_idx]) : 32'd0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      addr_q     <= '0;
      cs_q       <= 1'b0;
      write_n_q  <= 1'b1;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      cs_q       <= cs_d;
      write_n_q  <= write_n_d;
      wdata_q    <= wdata_d;
    end
  end

  assign owner              = owner_q;
  assign busy               = (hold_cnt_q != '0);
  assign avm.avm_address    = addr_q;
  assign avm.avm_chipselect = cs_q;
  assign avm.avm_write_n    = write_n_q;
  assign avm.avm_writedata  = wdata_q;

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Directed scenarios plus randomized traffic against a behavioural arbitration model.
module tb_hex_display_arbiter;

  localparam int NREQ  = 2;
  localparam int DW    = 16;
  localparam int HOLD  = 4;
  localparam int CNT_W = 26;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*DW-1:0] req_data = '0;
  logic [NREQ-1:0]   grant;
  logic [1:0]        owner;
  logic              busy;

  hex_display_arbiter_if bus ();

  hex_display_arbiter #(
    .NREQ(NREQ), .DW(DW), .HOLD_CYCLES(HOLD), .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req),
    .req_data (req_data),
    .grant    (grant),
    .owner    (owner),
    .busy     (busy),
    .avm      (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: who owns the display, whose turn is next, dwell cycles left.
  int          m_owner, m_rr, m_dwell;
  logic        m_wr_valid;
  logic [31:0] m_wr_data;

  task automatic do_reset();
    @(negedge clk);
    reset_n  = 1'b0;
    req      = '0;
    req_data = '0;
    repeat (3) @(negedge clk);
    reset_n    = 1'b1;
    m_owner    = 0;
    m_rr       = 0;
    m_dwell    = 0;
    m_wr_valid = 1'b0;
    m_wr_data  = '0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      n_checks++;
      if ({bus.avm_chipselect, bus.avm_write_n, bus.avm_address, bus.avm_writedata, grant, owner, busy}
          !== {1'b0, 1'b1, 2'd0, 32'd0, 2'b00, 2'd0, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_idle cycle %0d: cs=%b wr_n=%b addr=%0d wd=%h grant=%b owner=%0d busy=%b, want idle outputs",
                 i, bus.avm_chipselect, bus.avm_write_n, bus.avm_address, bus.avm_writedata, grant, owner, busy);
      end
    end
  endtask

  task automatic test_grant_and_write();
    @(negedge clk);
    req = 2'b01; req_data = {16'h0000, 16'h0123}; #1;
    n_checks++;
    if ({grant, bus.avm_chipselect} !== {2'b01, 1'b0}) begin
      n_fail++;
      $display("FAIL first_grant: grant=%b cs=%b, want grant=01 cs=0", grant, bus.avm_chipselect);
    end
    @(negedge clk);
    req = 2'b10; req_data = {16'hBEEF, 16'h0123}; #1;
    n_checks++;
    if ({bus.avm_chipselect, bus.avm_write_n, bus.avm_address, bus.avm_writedata} !== {1'b1, 1'b0, 2'd0, 32'h0000_0123}) begin
      n_fail++;
      $display("FAIL first_write: cs=%b wr_n=%b addr=%0d wd=%h, want 1 0 0 00000123",
               bus.avm_chipselect, bus.avm_write_n, bus.avm_address, bus.avm_writedata);
    end
    n_checks++;
    if ({grant, busy, owner} !== {2'b00, 1'b1, 2'd0}) begin
      n_fail++;
      $display("FAIL nonowner_wait: grant=%b busy=%b owner=%0d, want 00 1 0", grant, busy, owner);
    end
  endtask

  task automatic test_owner_refresh();
    @(negedge clk);
    req = 2'b11; req_data[15:0] = 16'h0124; #1;
    n_checks++;
    if ({grant, busy, bus.avm_chipselect} !== {2'b01, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL refresh_grant: grant=%b busy=%b cs=%b, want 01 1 0", grant, busy, bus.avm_chipselect);
    end
    @(negedge clk);
    req = 2'b10; #1;
    n_checks++;
    if ({bus.avm_chipselect, bus.avm_write_n, bus.avm_writedata, grant, busy} !== {1'b1, 1'b0, 32'h0000_0124, 2'b00, 1'b1}) begin
      n_fail++;
      $display("FAIL refresh_write: cs=%b wr_n=%b wd=%h grant=%b busy=%b, want 1 0 00000124 00 1",
               bus.avm_chipselect, bus.avm_write_n, bus.avm_writedata, grant, busy);
    end
    @(negedge clk); #1;
    n_checks++;
    if ({grant, busy, bus.avm_chipselect} !== {2'b00, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL dwell_not_reloaded: grant=%b busy=%b cs=%b, want 00 1 0", grant, busy, bus.avm_chipselect);
    end
  endtask

  task automatic test_hold_release();
    @(negedge clk); #1;
    n_checks++;
    if ({grant, busy} !== {2'b10, 1'b0}) begin
      n_fail++;
      $display("FAIL hold_release_grant: grant=%b busy=%b, want 10 0", grant, busy);
    end
    @(negedge clk);
    req = 2'b00; #1;
    n_checks++;
    if ({bus.avm_chipselect, bus.avm_writedata, owner, busy} !== {1'b1, 32'h0000_BEEF, 2'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL second_owner_write: cs=%b wd=%h owner=%0d busy=%b, want 1 0000beef 1 1",
               bus.avm_chipselect, bus.avm_writedata, owner, busy);
    end
  endtask

  task automatic test_round_robin();
    repeat (6) @(negedge clk);
    req = 2'b11; req_data = {16'hB2B2, 16'hA1A1}; #1;
    n_checks++;
    if (grant !== 2'b01) begin
      n_fail++;
      $display("FAIL rr_first: grant=%b, want 01", grant);
    end
    @(negedge clk);
    req = 2'b10; #1;
    n_checks++;
    if ({bus.avm_writedata, grant} !== {32'h0000_A1A1, 2'b00}) begin
      n_fail++;
      $display("FAIL rr_first_write: wd=%h grant=%b, want 0000a1a1 00", bus.avm_writedata, grant);
    end
    repeat (3) begin
      @(negedge clk); #1;
      n_checks++;
      if (grant !== 2'b00) begin
        n_fail++;
        $display("FAIL rr_hold_a: grant=%b, want 00", grant);
      end
    end
    @(negedge clk);
    req = 2'b11; req_data[15:0] = 16'hC3C3; #1;
    n_checks++;
    if (grant !== 2'b10) begin
      n_fail++;
      $display("FAIL rr_second: grant=%b, want 10", grant);
    end
    @(negedge clk);
    req = 2'b01; #1;
    n_checks++;
    if ({bus.avm_writedata, grant, owner} !== {32'h0000_B2B2, 2'b00, 2'd1}) begin
      n_fail++;
      $display("FAIL rr_second_write: wd=%h grant=%b owner=%0d, want 0000b2b2 00 1", bus.avm_writedata, grant, owner);
    end
    repeat (3) begin
      @(negedge clk); #1;
      n_checks++;
      if (grant !== 2'b00) begin
        n_fail++;
        $display("FAIL rr_hold_b: grant=%b, want 00", grant);
      end
    end
    @(negedge clk);
    req = 2'b11; req_data[31:16] = 16'hD4D4; #1;
    n_checks++;
    if (grant !== 2'b01) begin
      n_fail++;
      $display("FAIL rr_third: grant=%b, want 01", grant);
    end
    @(negedge clk);
    req = 2'b00; #1;
    n_checks++;
    if ({bus.avm_writedata, owner} !== {32'h0000_C3C3, 2'd0}) begin
      n_fail++;
      $display("FAIL rr_third_write: wd=%h owner=%0d, want 0000c3c3 0", bus.avm_writedata, owner);
    end
  endtask

  task automatic test_reset_in_grant();
    repeat (6) @(negedge clk);
    req = 2'b01; req_data = {16'h0000, 16'hE5E5}; #1;
    n_checks++;
    if (grant !== 2'b01) begin
      n_fail++;
      $display("FAIL pre_reset_grant: grant=%b, want 01", grant);
    end
    #1 reset_n = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if ({bus.avm_chipselect, bus.avm_write_n, bus.avm_address, bus.avm_writedata, owner, busy}
        !== {1'b0, 1'b1, 2'd0, 32'd0, 2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_drops_write: cs=%b wr_n=%b addr=%0d wd=%h owner=%0d busy=%b, want reset values",
               bus.avm_chipselect, bus.avm_write_n, bus.avm_address, bus.avm_writedata, owner, busy);
    end
    reset_n = 1'b1; #1;
    n_checks++;
    if (grant !== 2'b01) begin
      n_fail++;
      $display("FAIL regrant_after_reset: grant=%b, want 01", grant);
    end
    @(negedge clk);
    req = 2'b00; #1;
    n_checks++;
    if ({bus.avm_chipselect, bus.avm_writedata} !== {1'b1, 32'h0000_E5E5}) begin
      n_fail++;
      $display("FAIL write_after_reset: cs=%b wd=%h, want 1 0000e5e5", bus.avm_chipselect, bus.avm_writedata);
    end
  endtask

  task automatic test_random();
    logic [NREQ-1:0] r;
    logic [DW-1:0]   rd [NREQ];
    logic [NREQ-1:0] last_g;
    logic [NREQ-1:0] eg;
    int              w;
    int              idx;
    do_reset();
    r = '0;
    last_g = '0;
    for (int i = 0; i < NREQ; i++) rd[i] = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      // A requester holds its level until granted, then drops or presents fresh data.
      for (int i = 0; i < NREQ; i++) begin
        if (last_g[i]) begin
          r[i] = 1'($urandom_range(1, 0));
          if (r[i]) rd[i] = 16'($urandom);
        end else if (!r[i] && $urandom_range(3, 0) == 0) begin
          r[i]  = 1'b1;
          rd[i] = 16'($urandom);
        end
      end
      req = r;
      for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = rd[i];
      #1;

      w = -1;
      if (m_dwell == 0) begin
        for (int k = 0; k < NREQ; k++) begin
          idx = (m_rr + k) % NREQ;
          if (w < 0 && r[idx]) w = idx;
        end
      end else if (r[m_owner]) begin
        w = m_owner;
      end
      eg = (w >= 0) ? NREQ'(1 << w) : '0;

      n_checks++;
      if (grant !== eg) begin
        n_fail++;
        $display("FAIL rand_grant cycle %0d: grant=%b, want %b", cyc, grant, eg);
      end
      n_checks++;
      if ({bus.avm_chipselect, bus.avm_write_n, bus.avm_address, bus.avm_writedata}
          !== {m_wr_valid, !m_wr_valid, 2'd0, m_wr_valid ? m_wr_data : 32'd0}) begin
        n_fail++;
        $display("FAIL rand_write cycle %0d: cs=%b wr_n=%b addr=%0d wd=%h, want cs=%b wd=%h",
                 cyc, bus.avm_chipselect, bus.avm_write_n, bus.avm_address, bus.avm_writedata, m_wr_valid, m_wr_data);
      end
      n_checks++;
      if ({owner, busy} !== {2'(m_owner), (m_dwell > 0)}) begin
        n_fail++;
        $display("FAIL rand_owner_busy cycle %0d: owner=%0d busy=%b, want %0d %b",
                 cyc, owner, busy, m_owner, (m_dwell > 0));
      end

      m_wr_valid = (w >= 0);
      m_wr_data  = (w >= 0) ? 32'(rd[w]) : 32'd0;
      if (m_dwell == 0) begin
        if (w >= 0) begin
          m_owner = w;
          m_rr    = (w + 1) % NREQ;
          m_dwell = HOLD;
        end
      end else begin
        m_dwell--;
      end
      last_g = eg;
    end
    req = '0;
  endtask

  initial begin
    do_reset();
    test_reset();
    test_grant_and_write();
    test_owner_refresh();
    test_hold_release();
    test_round_robin();
    test_reset_in_grant();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
